// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler
// Sequences one in-place radix-2 Cooley-Tukey NTT over a dual-port
// coefficient RAM. Each butterfly runs READ (1 cycle), WAIT (BF_LATENCY
// cycles) and WRITE (1 cycle). Butterflies never overlap, so the two RAM
// ports can never conflict.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a transform (sampled in IDLE only)
//   abort           cancel a transform in progress
//   busy            high while READ/WAIT/WRITE
//   done            one-cycle pulse after the final write
//   addr_a, addr_b  RAM port A/B addresses (a, b = a | len)
//   we_a, we_b      RAM write enables (WRITE cycle only)
//   tw_addr         twiddle ROM index, valid with bf_in_valid
//   bf_in_valid     RAM read data holds the butterfly operands this cycle
//   stage           current stage s
module ntt_bf_scheduler #(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int BF_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         addr_a,
    output logic [ADDR_WIDTH-1:0]         addr_b,
    output logic                          we_a,
    output logic                          we_b,
    output logic [ADDR_WIDTH-2:0]         tw_addr,
    output logic                          bf_in_valid,
    output logic [$clog2(ADDR_WIDTH)-1:0] stage
);

    localparam int STAGE_W = $clog2(ADDR_WIDTH);
    localparam int KW      = ADDR_WIDTH - 1;
    localparam int WCNT_W  = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    localparam logic [KW-1:0]      K_LAST = KW'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(ADDR_WIDTH - 1);
    localparam logic [WCNT_W-1:0]  W_LAST = WCNT_W'(BF_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [KW-1:0]      k, k_nx;
    logic [STAGE_W-1:0] s, s_nx;
    logic [WCNT_W-1:0]  wcnt, wcnt_nx;

    // Lower butterfly address: insert a zero bit at position s of k.
    function automatic logic [ADDR_WIDTH-1:0] addr_lo(
        input logic [KW-1:0]      kk,
        input logic [STAGE_W-1:0] ss
    );
        logic [ADDR_WIDTH-1:0] kx;
        logic [ADDR_WIDTH-1:0] mask;
        kx   = {1'b0, kk};
        mask = (ADDR_WIDTH'(1) << ss) - ADDR_WIDTH'(1);
        return (((kx >> ss) << ss) << 1) | (kx & mask);
    endfunction

    // Twiddle index: position inside the group, scaled so that every stage
    // indexes the same N/2-entry ROM.
    function automatic logic [KW-1:0] tw_of(
        input logic [KW-1:0]      kk,
        input logic [STAGE_W-1:0] ss
    );
        logic [KW-1:0]      mask;
        logic [STAGE_W-1:0] sh;
        mask = KW'((ADDR_WIDTH'(1) << ss) - ADDR_WIDTH'(1));
        sh   = S_LAST - ss;
        return (kk & mask) << sh;
    endfunction

    // Next-state and counter logic. abort wins over start in IDLE and sends
    // every active state straight back to IDLE.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        s_nx     = s;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = READ;
                    k_nx     = '0;
                    s_nx     = '0;
                end
            end
            READ: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT;
                    wcnt_nx  = '0;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (wcnt == W_LAST) begin
                    state_nx = WRITE;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (k != K_LAST) begin
                    k_nx     = k + 1'b1;
                    state_nx = READ;
                end else if (s != S_LAST) begin
                    k_nx     = '0;
                    s_nx     = s + 1'b1;
                    state_nx = READ;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register plus registered outputs. Outputs are derived from the
    // state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            s           <= '0;
            wcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            we_a        <= 1'b0;
            we_b        <= 1'b0;
            bf_in_valid <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            tw_addr     <= '0;
        end else begin
            state       <= state_nx;
            k           <= k_nx;
            s           <= s_nx;
            wcnt        <= wcnt_nx;
            busy        <= (state_nx == READ) || (state_nx == WAIT) || (state_nx == WRITE);
            done        <= (state_nx == DONE);
            we_a        <= (state_nx == WRITE);
            we_b        <= (state_nx == WRITE);
            // RAM read latency is one cycle: operands appear in the first WAIT cycle.
            bf_in_valid <= (state == READ) && (state_nx == WAIT);
            if (state_nx == READ) begin
                addr_a <= addr_lo(k_nx, s_nx);
                addr_b <= addr_lo(k_nx, s_nx) | (ADDR_WIDTH'(1) << s_nx);
            end
            if ((state == READ) && (state_nx == WAIT)) begin
                tw_addr <= tw_of(k, s);
            end
        end
    end

    assign stage = s;

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// tb_ntt_bf_scheduler
// Self-checking bench for ntt_bf_scheduler with N=8, ADDR_WIDTH=3,
// BF_LATENCY=4. A behavioural model tracks how many cycles have passed
// since the transform started and derives every expected output from the
// butterfly index with plain arithmetic; literal tables pin the model.
module tb_ntt_bf_scheduler;

    localparam int N      = 8;
    localparam int AW     = 3;
    localparam int BFL    = 4;
    localparam int P      = BFL + 2;
    localparam int HALF   = N / 2;
    localparam int TOTAL  = AW * HALF;
    localparam int DONE_C = TOTAL * P + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          we_a;
    logic          we_b;
    logic [AW-2:0] tw_addr;
    logic          bf_in_valid;
    logic [1:0]    stage;

    int checks = 0;
    int errors = 0;

    int lit_a  [TOTAL] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b  [TOTAL] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw [TOTAL] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    bit m_valid   = 0;
    bit m_running = 0;
    bit m_fresh   = 0;
    int m_c       = 0;

    int idx, ph, es, ek, elen, ea, eb, etw;
    bit e_busy, e_done, e_we, e_bf;

    ntt_bf_scheduler #(
        .N(N),
        .ADDR_WIDTH(AW),
        .BF_LATENCY(BFL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .we_a(we_a),
        .we_b(we_b),
        .tw_addr(tw_addr),
        .bf_in_valid(bf_in_valid),
        .stage(stage)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic start_v, input logic abort_v, input logic rst_v);
        start = start_v;
        abort = abort_v;
        rst   = rst_v;
    endtask

    // Starts a transform and follows it to the done pulse, pinning the READ
    // addresses and twiddle indices against the hand-computed tables.
    // Returns with the done cycle's outputs just sampled and inputs idle.
    task automatic runFull(input string tag, output int done_at);
        int i;
        done_at = 0;
        applyStimulus(1, 0, 0);
        for (int n = 1; n <= 200 && done_at == 0; n++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0);
            i = (n - 1) / P;
            if (i < TOTAL && (n - 1) % P == 0) begin
                checkOutput({tag, "_lit_addr_a"}, 32'(addr_a), lit_a[i]);
                checkOutput({tag, "_lit_addr_b"}, 32'(addr_b), lit_b[i]);
            end
            if (i < TOTAL && (n - 1) % P == 1) begin
                checkOutput({tag, "_lit_bf_valid"}, 32'(bf_in_valid), 1);
                checkOutput({tag, "_lit_tw"}, 32'(tw_addr), lit_tw[i]);
            end
            if (done) done_at = n;
        end
        checkOutput({tag, "_done_cycle"}, done_at, DONE_C);
    endtask

    // Behavioural model: advances on the same edge the DUT samples its
    // inputs, counting cycles since start (1 = first READ, DONE_C = done).
    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_running = 0;
            m_c       = 0;
            m_fresh   = 1;
        end else if (m_running) begin
            if (m_c == DONE_C || abort) begin
                m_running = 0;
                m_c       = 0;
            end else begin
                m_c++;
            end
        end else if (start && !abort) begin
            m_running = 1;
            m_c       = 1;
            m_fresh   = 0;
        end
    end

    // Compare process: every cycle, away from the active edge, compare the
    // DUT against what the model says this cycle should look like.
    always @(negedge clk) begin
        if (m_valid) begin
            e_busy = m_running && (m_c < DONE_C);
            e_done = m_running && (m_c == DONE_C);
            idx    = (m_c - 1) / P;
            ph     = (m_c - 1) % P;
            es     = idx / HALF;
            ek     = idx % HALF;
            elen   = 1 << es;
            ea     = (ek / elen) * 2 * elen + ek % elen;
            eb     = ea + elen;
            etw    = (ek % elen) * (HALF / elen);
            e_we   = e_busy && (ph == P - 1);
            e_bf   = e_busy && (ph == 1);
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("done", 32'(done), 32'(e_done));
            checkOutput("we_a", 32'(we_a), 32'(e_we));
            checkOutput("we_b", 32'(we_b), 32'(e_we));
            checkOutput("bf_in_valid", 32'(bf_in_valid), 32'(e_bf));
            if (e_busy) begin
                checkOutput("addr_a", 32'(addr_a), ea);
                checkOutput("addr_b", 32'(addr_b), eb);
                checkOutput("stage", 32'(stage), es);
            end
            if (e_bf) begin
                checkOutput("tw_addr", 32'(tw_addr), etw);
            end
            if (m_fresh) begin
                checkOutput("reset_addr_a", 32'(addr_a), 0);
                checkOutput("reset_addr_b", 32'(addr_b), 0);
                checkOutput("reset_tw", 32'(tw_addr), 0);
                checkOutput("reset_stage", 32'(stage), 0);
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        int done_at;
        applyStimulus(0, 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_we", 32'({we_a, we_b}), 0);
        checkOutput("rst_bf", 32'(bf_in_valid), 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);

        // start together with abort in IDLE: abort wins
        applyStimulus(1, 1, 0);
        @(negedge clk);
        checkOutput("start_abort_idle", 32'(busy), 0);

        // Run 1: full transform, then start in the DONE cycle is ignored
        runFull("run1", done_at);
        applyStimulus(1, 0, 0);
        @(negedge clk);
        checkOutput("done_start_ignored", 32'(busy), 0);
        @(negedge clk);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_addr_a", 32'(addr_a), 0);
        checkOutput("restart_addr_b", 32'(addr_b), 1);
        applyStimulus(0, 0, 0);

        // Run 2: start pulses while busy, abort in WAIT of s=1, k=2
        for (int n = 2; n <= 50; n++) begin
            @(negedge clk);
            if (n == 37) begin
                checkOutput("run2_stage", 32'(stage), 1);
                checkOutput("run2_addr_a", 32'(addr_a), lit_a[6]);
                checkOutput("run2_addr_b", 32'(addr_b), lit_b[6]);
            end
            if (n >= 40) begin
                checkOutput("abort_busy", 32'(busy), 0);
                checkOutput("abort_we", 32'({we_a, we_b}), 0);
                checkOutput("abort_done", 32'(done), 0);
            end
            applyStimulus((n == 3) || (n == 10) || (n == 20), n == 39, 0);
        end
        applyStimulus(0, 0, 0);

        // Run 3: reset held for 3 cycles in the middle of WAIT
        applyStimulus(1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        checkOutput("run3_busy", 32'(busy), 1);
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 1);
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_we", 32'({we_a, we_b}), 0);
        checkOutput("midrst_bf", 32'(bf_in_valid), 0);
        checkOutput("midrst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0);
        @(negedge clk);

        // Run 4: full transform from s=0, k=0 after the reset
        runFull("run4", done_at);
        @(negedge clk);

        // Run 5: abort coinciding with the first WRITE
        applyStimulus(1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        repeat (5) @(negedge clk);
        checkOutput("abort_write_we", 32'(we_a), 1);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        checkOutput("post_abort_busy", 32'(busy), 0);
        checkOutput("post_abort_we", 32'(we_b), 0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
